// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with valid/ready
// handshakes, round-robin grant, registered ALU operands and a held result.
// Ports: clk_i/rst_i (sync active-high); req_valid_i/req_ready_o,
//   req_data1_i/req_data2_i/req_ctrl_i (packed per requester);
//   rsp_valid_o/rsp_ready_i/rsp_data_o; alu_data1_o/alu_data2_o/alu_ctrl_o
//   drive the ALU, alu_data_i is its result.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority
//   (requester 0 always wins); default is round-robin.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*DATA_W-1:0] req_data1_i,
    input  logic [2*DATA_W-1:0] req_data2_i,
    input  logic [2*CTRL_W-1:0] req_ctrl_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic [DATA_W-1:0]   alu_data1_o,
    output logic [DATA_W-1:0]   alu_data2_o,
    output logic [CTRL_W-1:0]   alu_ctrl_o,
    input  logic [DATA_W-1:0]   alu_data_i
);

    localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] CTRL_MUL = CTRL_W'(4'b0111);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                owner;
    logic [3:0]          cnt;
    logic [1:0]          grant;
    logic                accept;
    logic                win;
    logic [DATA_W-1:0]   sel_data1;
    logic [DATA_W-1:0]   sel_data2;
    logic [CTRL_W-1:0]   sel_ctrl;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Names the requester preferred on the next tie.
    logic ptr;
`endif

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && !rst_i) begin
            case (req_valid_i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   grant = 2'b01;
`else
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept    = |grant;
    assign win       = grant[1];
    assign sel_data1 = req_data1_i[(win ? DATA_W : 0) +: DATA_W];
    assign sel_data2 = req_data2_i[(win ? DATA_W : 0) +: DATA_W];
    assign sel_ctrl  = req_ctrl_i[(win ? CTRL_W : 0) +: CTRL_W];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    if (cnt == 4'd1) state_nx = RESP;
            RESP:    if (rsp_ready_i[owner]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o = grant;
        rsp_valid_o = 2'b00;
        if (state == RESP && !rst_i)
            rsp_valid_o = owner ? 2'b10 : 2'b01;
    end

    // Datapath: operand registers, hold counter, result capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner       <= 1'b0;
            cnt         <= 4'd0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            alu_ctrl_o  <= CTRL_ADD;
            rsp_data_o  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr         <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_data1_o <= sel_data1;
                alu_data2_o <= sel_data2;
                alu_ctrl_o  <= sel_ctrl;
                owner       <= win;
                cnt         <= (sel_ctrl == CTRL_MUL) ? 4'(MUL_LAT) : 4'd1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                ptr         <= ~win;
`endif
            end
            if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) rsp_data_o <= alu_data_i;
            end
        end
    end

endmodule
